program_sequencer_stack: RTL and testbench
==========================================

# program_sequencer_stack

Parametrised next-generation program sequencer for the MPU family. It generates the program-memory fetch address and supports unconditional and conditional (zero-flag) jumps. It adds hardware subroutine call/return through a configurable-depth return-address stack, a fetch-hold input, and sticky stack-fault flags. It drives the program memory address bus and takes its control inputs from the instruction decoder and computational unit.

## Interface
Parameters:
- PM_ADDR_W, 8, width of program-memory address (ROM depth = 2^PM_ADDR_W)
- JMP_ADDR_W, 4, width of jump/call target field from decoder (≤ PM_ADDR_W)
- STACK_DEPTH, 4, number of return-address entries (≥1)
- LEVEL_W, 3, width of stack_level (must hold 0..STACK_DEPTH)

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- sync_reset  in  1  synchronous active-high restart from address 0
- hold  in  1  freeze sequencer (pm_addr and stack unchanged)
- jmp  in  1  unconditional jump
- jmp_nz  in  1  conditional jump, taken when dont_jmp = 0
- dont_jmp  in  1  zero flag from computational unit
- call  in  1  push return address, jump to target
- ret  in  1  pop return address into pm_addr
- jmp_addr  in  JMP_ADDR_W  target for jmp/jmp_nz/call, zero-extended to PM_ADDR_W
- pm_addr  out  PM_ADDR_W  registered program-memory address
- stack_level  out  LEVEL_W  current stack occupancy
- overflow  out  1  sticky: call issued with stack full
- underflow  out  1  sticky: ret issued with stack empty

## Operation
- Next-address selection, strict priority (first match wins):
  1. sync_reset: pm_addr←0, stack_level←0, overflow←0, underflow←0.
  2. hold: all state unchanged.
  3. ret: if stack_level>0, pm_addr←top entry, level−1; else pm_addr←pm_addr+1, underflow←1.
  4. call: if stack_level<STACK_DEPTH, push pm_addr+1, pm_addr←target, level+1; else pm_addr←pm_addr+1, no push, overflow←1.
  5. jmp: pm_addr←target.
  6. jmp_nz and dont_jmp=0: pm_addr←target.
  7. Otherwise: pm_addr←pm_addr+1.
- Target = {zeros, jmp_addr}.
- Increment is modulo 2^PM_ADDR_W: all-ones wraps to 0. A pushed return address also wraps, so a call at all-ones pushes 0.
- Stack is LIFO, STACK_DEPTH × PM_ADDR_W registers indexed by stack_level. Popped entries need not be cleared.
- overflow/underflow clear only on reset or sync_reset.
- Simultaneous call and ret: ret wins, call ignored, no fault flagged for the call.
- jmp_nz with dont_jmp=1 behaves as increment.

## Timing
- Reset (reset=0, asynchronous): pm_addr=0, stack_level=0, overflow=0, underflow=0 immediately, held until release.
- All outputs are registered, with no combinational path from inputs to outputs.
- Control inputs sampled at rising edge N take effect on pm_addr at edge N (visible after N). Single-cycle latency, no pipeline bubbles.
- Program memory is clocked on the falling edge, so the instruction at pm_addr is available before the next rising edge.
- hold asserted for k cycles freezes pm_addr for exactly k cycles.
- Reset mid-call/ret: asynchronous reset overrides; stack contents are discarded and level returns to 0.

## Test plan
- Reset and free-run, default params: release reset, idle for 260 cycles → pm_addr 0,1,…,255,0,1,2,3; flags 0.
- Jumps: at pm_addr=5 assert jmp with jmp_addr=0xA → next pm_addr=0x0A. jmp_nz with dont_jmp=1 at 0x0A → 0x0B. jmp_nz with dont_jmp=0, jmp_addr=3 → 0x03.
- Nested calls: call 0x4 at pm_addr 0x10, call 0x8 at 0x05, then ret, ret → pm_addr sequence 0x04, 0x05, 0x08, 0x06, 0x11; stack_level 1,2,1,0.
- Overflow/underflow: five calls with STACK_DEPTH=4 → fifth call gives pm_addr+1, level stays 4, overflow=1. Five rets → after four, level=0; fifth gives pm_addr+1, underflow=1. sync_reset clears both flags.
- Hold and priority: hold during call → no change. call and ret together with level=2 → pop, level=1, no overflow.
- Async reset mid-operation with PM_ADDR_W=10, STACK_DEPTH=8: drop reset at level 3 between edges → outputs 0 without a clock edge; after release, the first ret sets underflow.

Source files
------------

// File: rtl/program_sequencer_stack.sv
// Program-memory address sequencer with jumps, call/return stack and sticky stack-fault flags.
// One-cycle latency from control inputs to pm_addr; hold freezes all state for as long as it is high.
module program_sequencer_stack #(
    parameter int PM_ADDR_W   = 8,
    parameter int JMP_ADDR_W  = 4,
    parameter int STACK_DEPTH = 4,
    parameter int LEVEL_W     = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sync_reset,
    input  logic                  hold,
    input  logic                  jmp,
    input  logic                  jmp_nz,
    input  logic                  dont_jmp,
    input  logic                  call,
    input  logic                  ret,
    input  logic [JMP_ADDR_W-1:0] jmp_addr,
    output logic [PM_ADDR_W-1:0]  pm_addr,
    output logic [LEVEL_W-1:0]    stack_level,
    output logic                  overflow,
    output logic                  underflow
);

    logic [PM_ADDR_W-1:0] stack_mem [STACK_DEPTH];
    logic [PM_ADDR_W-1:0] pm_inc;
    logic [PM_ADDR_W-1:0] target;
    logic [PM_ADDR_W-1:0] top;
    logic [PM_ADDR_W-1:0] pm_next;
    logic [LEVEL_W-1:0]   level_next;
    logic                 ovf_next;
    logic                 unf_next;
    logic                 push;

    assign pm_inc = pm_addr + PM_ADDR_W'(1);
    assign target = PM_ADDR_W'(jmp_addr);

    // Top of stack is the entry just below the current occupancy.
    always_comb begin
        top = '0;
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (stack_level == LEVEL_W'(i + 1)) begin
                top = stack_mem[i];
            end
        end
    end

    always_comb begin
        pm_next    = pm_inc;
        level_next = stack_level;
        ovf_next   = overflow;
        unf_next   = underflow;
        push       = 1'b0;
        if (sync_reset) begin
            pm_next    = '0;
            level_next = '0;
            ovf_next   = 1'b0;
            unf_next   = 1'b0;
        end else if (hold) begin
            pm_next = pm_addr;
        end else if (ret) begin
            if (stack_level != '0) begin
                pm_next    = top;
                level_next = stack_level - LEVEL_W'(1);
            end else begin
                unf_next = 1'b1;
            end
        end else if (call) begin
            if (stack_level < LEVEL_W'(STACK_DEPTH)) begin
                push       = 1'b1;
                pm_next    = target;
                level_next = stack_level + LEVEL_W'(1);
            end else begin
                ovf_next = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            pm_next = target;
        end
    end

    // Stack contents need no reset: occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (stack_level == LEVEL_W'(i)) begin
                    stack_mem[i] <= pm_inc;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pm_addr     <= '0;
            stack_level <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            pm_addr     <= pm_next;
            stack_level <= level_next;
            overflow    <= ovf_next;
            underflow   <= unf_next;
        end
    end

endmodule

// File: tb/tb_program_sequencer_stack.sv
// Bench for program_sequencer_stack: two configurations (8/4 and 10/8) share stimulus and
// are checked every cycle against a stack-based reference model plus literal expectations.
module tb_program_sequencer_stack;

    logic       clk = 1'b0;
    logic       reset, sync_reset, hold, jmp, jmp_nz, dont_jmp, call, ret;
    logic [3:0] jmp_addr;

    logic [7:0] pm_a;
    logic [2:0] lvl_a;
    logic       ovf_a, unf_a;
    logic [9:0] pm_b;
    logic [3:0] lvl_b;
    logic       ovf_b, unf_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    int m_pc  [2];
    int m_lvl [2];
    bit m_ovf [2];
    bit m_unf [2];
    int m_stk [2][16];

    always #5 clk = ~clk;

    program_sequencer_stack dut_a (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .hold(hold), .jmp(jmp),
        .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr),
        .pm_addr(pm_a), .stack_level(lvl_a), .overflow(ovf_a), .underflow(unf_a)
    );

    program_sequencer_stack #(
        .PM_ADDR_W(10), .JMP_ADDR_W(4), .STACK_DEPTH(8), .LEVEL_W(4)
    ) dut_b (
        .clk(clk), .reset(reset), .sync_reset(sync_reset), .hold(hold), .jmp(jmp),
        .jmp_nz(jmp_nz), .dont_jmp(dont_jmp), .call(call), .ret(ret), .jmp_addr(jmp_addr),
        .pm_addr(pm_b), .stack_level(lvl_b), .overflow(ovf_b), .underflow(unf_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int k = 0; k < 2; k++) begin
            m_pc[k] = 0; m_lvl[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end
    endtask

    task automatic model_step(input int k, input int aw, input int depth);
        int inc;
        inc = (m_pc[k] + 1) % (1 << aw);
        if (sync_reset) begin
            m_pc[k] = 0; m_lvl[k] = 0; m_ovf[k] = 1'b0; m_unf[k] = 1'b0;
        end else if (hold) begin
            // frozen
        end else if (ret) begin
            if (m_lvl[k] > 0) begin
                m_lvl[k] = m_lvl[k] - 1;
                m_pc[k]  = m_stk[k][m_lvl[k]];
            end else begin
                m_pc[k] = inc; m_unf[k] = 1'b1;
            end
        end else if (call) begin
            if (m_lvl[k] < depth) begin
                m_stk[k][m_lvl[k]] = inc;
                m_lvl[k] = m_lvl[k] + 1;
                m_pc[k]  = int'(jmp_addr);
            end else begin
                m_pc[k] = inc; m_ovf[k] = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            m_pc[k] = int'(jmp_addr);
        end else begin
            m_pc[k] = inc;
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("a_pm",  32'(pm_a),  32'(m_pc[0]));
            check("a_lvl", 32'(lvl_a), 32'(m_lvl[0]));
            check("a_ovf", 32'(ovf_a), 32'(m_ovf[0]));
            check("a_unf", 32'(unf_a), 32'(m_unf[0]));
            check("b_pm",  32'(pm_b),  32'(m_pc[1]));
            check("b_lvl", 32'(lvl_b), 32'(m_lvl[1]));
            check("b_ovf", 32'(ovf_b), 32'(m_ovf[1]));
            check("b_unf", 32'(unf_b), 32'(m_unf[1]));
        end
    end

    // Drive one cycle of controls, let the edge happen, update the model, return at the falling edge.
    task automatic cyc(input logic sr, input logic h, input logic j, input logic jn,
                       input logic dz, input logic c, input logic r, input logic [3:0] a);
        sync_reset = sr; hold = h; jmp = j; jmp_nz = jn; dont_jmp = dz;
        call = c; ret = r; jmp_addr = a;
        @(posedge clk);
        model_step(0, 8, 4);
        model_step(1, 10, 8);
        @(negedge clk);
        sync_reset = 0; hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0; call = 0; ret = 0; jmp_addr = 0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 4'h0);
    endtask

    initial begin
        logic [7:0] held_pc;
        reset = 1'b1; sync_reset = 0; hold = 0; jmp = 0; jmp_nz = 0; dont_jmp = 0;
        call = 0; ret = 0; jmp_addr = 0;
        model_clear();
        #1 reset = 1'b0;
        #2;
        check("rst_pm_a",  32'(pm_a), 32'h0);
        check("rst_lvl_a", 32'(lvl_a), 32'h0);
        check("rst_flags", 32'({ovf_a, unf_a, ovf_b, unf_b}), 32'h0);
        check("rst_pm_b",  32'(pm_b), 32'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        chk_en = 1'b1;

        // Free run: address wraps at 256 on the 8-bit instance only.
        idle(256);
        check("wrap_a", 32'(pm_a), 32'h0);
        check("wrap_b", 32'(pm_b), 32'd256);
        idle(3);
        check("run_a_3", 32'(pm_a), 32'h3);

        // Jumps
        cyc(1, 0, 0, 0, 0, 0, 0, 4'h0);
        idle(5);
        check("at5", 32'(pm_a), 32'h5);
        cyc(0, 0, 1, 0, 0, 0, 0, 4'hA);
        check("jmp", 32'(pm_a), 32'h0A);
        cyc(0, 0, 0, 1, 1, 0, 0, 4'h3);
        check("jnz_not_taken", 32'(pm_a), 32'h0B);
        cyc(0, 0, 0, 1, 0, 0, 0, 4'h3);
        check("jnz_taken", 32'(pm_a), 32'h03);

        // Nested calls from 0x10
        cyc(0, 0, 1, 0, 0, 0, 0, 4'hF);
        idle(1);
        check("at10", 32'(pm_a), 32'h10);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'h4);
        check("call1_pm", 32'(pm_a), 32'h04);
        check("call1_lvl", 32'(lvl_a), 32'd1);
        idle(1);
        check("step_pm", 32'(pm_a), 32'h05);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'h8);
        check("call2_pm", 32'(pm_a), 32'h08);
        check("call2_lvl", 32'(lvl_a), 32'd2);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'h0);
        check("ret1_pm", 32'(pm_a), 32'h06);
        check("ret1_lvl", 32'(lvl_a), 32'd1);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'h0);
        check("ret2_pm", 32'(pm_a), 32'h11);
        check("ret2_lvl", 32'(lvl_a), 32'd0);

        // Overflow: fifth call at 0x02 only increments on the depth-4 instance
        cyc(0, 0, 0, 0, 0, 1, 0, 4'h2);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 1, 0, 4'h2);
        check("ovf_pm", 32'(pm_a), 32'h03);
        check("ovf_lvl", 32'(lvl_a), 32'd4);
        check("ovf_flag", 32'(ovf_a), 32'h1);
        check("ovf_b_clear", 32'(ovf_b), 32'h0);
        for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 0, 0, 1, 4'h0);
        check("pop4_pm", 32'(pm_a), 32'h12);
        check("pop4_lvl", 32'(lvl_a), 32'd0);
        cyc(0, 0, 0, 0, 0, 0, 1, 4'h0);
        check("unf_pm", 32'(pm_a), 32'h13);
        check("unf_flag", 32'(unf_a), 32'h1);
        check("ovf_sticky", 32'(ovf_a), 32'h1);
        cyc(1, 0, 0, 0, 0, 0, 0, 4'h0);
        check("sr_flags", 32'({ovf_a, unf_a}), 32'h0);

        // Hold and call/ret priority
        idle(2);
        held_pc = pm_a;
        cyc(0, 1, 0, 0, 0, 1, 0, 4'h9);
        check("hold_call_pm", 32'(pm_a), 32'(held_pc));
        check("hold_call_lvl", 32'(lvl_a), 32'd0);
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 0, 0, 0, 0, 4'h0);
        check("hold3_pm", 32'(pm_a), 32'(held_pc));
        cyc(0, 0, 0, 0, 0, 1, 0, 4'h4);
        cyc(0, 0, 0, 0, 0, 1, 0, 4'h8);
        cyc(0, 0, 0, 0, 0, 1, 1, 4'hC);
        check("callret_pm", 32'(pm_a), 32'h05);
        check("callret_lvl", 32'(lvl_a), 32'd1);
        check("callret_ovf", 32'(ovf_a), 32'h0);

        // Randomised traffic
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                1'($urandom_range(0, 1)), ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 4) == 0), 4'($urandom_range(0, 15)));
        end

        // Asynchronous reset between edges at stack level 3
        cyc(1, 0, 0, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 1, 0, 4'h7);
        check("pre_arst_lvl_b", 32'(lvl_b), 32'd3);
        #2 reset = 1'b0;
        model_clear();
        #1;
        check("arst_pm_b", 32'(pm_b), 32'h0);
        check("arst_lvl_b", 32'(lvl_b), 32'h0);
        check("arst_lvl_a", 32'(lvl_a), 32'h0);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        cyc(0, 0, 0, 0, 0, 0, 1, 4'h0);
        check("post_arst_unf_b", 32'(unf_b), 32'h1);
        check("post_arst_pm_b", 32'(pm_b), 32'h1);

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
